comb_sort_seq: RTL and testbench

Parametrised, sequential successor of the lab's combinational logic-plus-adder min/max block. It accepts N operand lanes, applies a per-lane selectable bitwise op, and adds adjacent lane results into M = N/2 sums. It then sorts the sums iteratively, ascending or descending, and presents them on a valid/ready output. It sits between an upstream valid/ready producer and a downstream consumer that may stall.

---
 rtl/comb_sort_seq_if.sv | 29 ++
 rtl/comb_sort_seq.sv | 121 ++++++++++++
 tb/tb_comb_sort_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/comb_sort_seq_if.sv
// Valid/ready bundle for comb_sort_seq: N operand lanes in, M = N/2 sorted sums out.
// A beat moves on a rising edge where valid and ready are both high; a producer
// holds its valid and payload until that edge, and ready never depends on valid.
interface comb_sort_seq_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int M = N / 2;

    logic                 in_valid;
    logic                 in_ready;
    logic [N*W-1:0]       in_a;
    logic [N*W-1:0]       in_b;
    logic [2*N-1:0]       in_op;
    logic                 in_desc;
    logic                 out_valid;
    logic                 out_ready;
    logic [M*(W+1)-1:0]   out_num;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_desc, out_ready,
        output in_ready, out_valid, out_num
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_desc, out_ready,
        input  in_ready, out_valid, out_num
    );
endinterface

// File: rtl/comb_sort_seq.sv
// Per-lane bitwise op, pairwise lane sums, then an odd-even transposition sort
// of the sums (one pass per cycle) presented on a valid/ready output.
module comb_sort_seq #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    comb_sort_seq_if.slave    bus,
    output logic [1:0]        dbg_state_o
);
    localparam int M  = N / 2;
    localparam int SW = W + 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   arr_q [M];
    logic [SW-1:0]   arr_d [M];
    logic [CW-1:0]   pass_q, pass_d;
    logic            desc_q, desc_d;

    logic [W-1:0]    lane_r [N];
    logic [SW-1:0]   sum    [M];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            unique case (bus.in_op[2*i +: 2])
                2'b00:   lane_r[i] = bus.in_a[i*W +: W] & bus.in_b[i*W +: W];
                2'b01:   lane_r[i] = bus.in_a[i*W +: W] | bus.in_b[i*W +: W];
                2'b10:   lane_r[i] = bus.in_a[i*W +: W] ^ bus.in_b[i*W +: W];
                default: lane_r[i] = ~(bus.in_a[i*W +: W] ^ bus.in_b[i*W +: W]);
            endcase
        end
    end

    // W+1 bits hold the largest possible sum, so no carry is lost.
    always_comb begin
        for (int j = 0; j < M; j++) begin
            sum[j] = {1'b0, lane_r[2*j]} + {1'b0, lane_r[2*j+1]};
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        desc_d  = desc_q;
        for (int k = 0; k < M; k++) begin
            arr_d[k] = arr_q[k];
        end

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int j = 0; j < M; j++) begin
                        arr_d[j] = sum[j];
                    end
                    desc_d  = bus.in_desc;
                    pass_d  = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                // Pairs of one pass are disjoint, so each reads arr_q independently.
                for (int k = 0; k < M - 1; k++) begin
                    if ((k % 2) == int'(pass_q[0])) begin
                        if (desc_q ? (arr_q[k] < arr_q[k+1]) : (arr_q[k] > arr_q[k+1])) begin
                            arr_d[k]   = arr_q[k+1];
                            arr_d[k+1] = arr_q[k];
                        end
                    end
                end
                if (pass_q == CW'(M - 1)) begin
                    state_d = DONE;
                end else begin
                    pass_d = pass_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= '0;
            desc_q  <= 1'b0;
            for (int k = 0; k < M; k++) begin
                arr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            desc_q  <= desc_d;
            for (int k = 0; k < M; k++) begin
                arr_q[k] <= arr_d[k];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign dbg_state_o   = state_q;

    always_comb begin
        bus.out_num = '0;
        for (int k = 0; k < M; k++) begin
            bus.out_num[k*SW +: SW] = arr_q[k];
        end
    end
endmodule

// File: tb/tb_comb_sort_seq.sv
// Directed bench for comb_sort_seq with a 4-lane and an 8-lane instance.
module tb_comb_sort_seq;
    localparam int W = 4;

    localparam logic [15:0] A_LAB  = {4'd12, 4'd5, 4'd3, 4'd5};
    localparam logic [15:0] B_LAB  = {4'd9, 4'd12, 4'd9, 4'd3};
    localparam logic [7:0]  OP_LAB = {2'b10, 2'b00, 2'b01, 2'b11};

    localparam logic [31:0] A_SEQ  = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    localparam logic [31:0] A_UNS  = {4'd4, 4'd3, 4'd6, 4'd5, 4'd2, 4'd1, 4'd7, 4'd8};

    localparam logic [15:0] A_P2   = 16'hFFFF;
    localparam logic [15:0] B_P2   = {4'd1, 4'd7, 4'd12, 4'd3};

    logic clk;
    logic rst_n;
    logic [1:0] dbg4, dbg8;
    int checks;
    int errors;

    comb_sort_seq_if #(.W(W), .N(4)) if4 ();
    comb_sort_seq_if #(.W(W), .N(8)) if8 ();

    comb_sort_seq #(.W(W), .N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state_o(dbg4));
    comb_sort_seq #(.W(W), .N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8), .dbg_state_o(dbg8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic launch4(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                           input logic desc, output int edges);
        if4.in_a = a; if4.in_b = b; if4.in_op = op; if4.in_desc = desc; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        edges = 1;
        while (if4.out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic launch8(input logic [31:0] a, input logic [31:0] b, input logic [15:0] op,
                           input logic desc, output int edges);
        if8.in_a = a; if8.in_b = b; if8.in_op = op; if8.in_desc = desc; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        edges = 1;
        while (if8.out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        #7;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b want 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b want 1", if4.in_ready); end
        checks++; if (if4.out_num !== 10'd0) begin errors++; $display("FAIL reset_out_num4: got %h want 0", if4.out_num); end
        checks++; if (if8.out_num !== 20'd0) begin errors++; $display("FAIL reset_out_num8: got %h want 0", if8.out_num); end
        checks++; if (dbg8 !== 2'd0) begin errors++; $display("FAIL reset_state8: got %0d want 0", dbg8); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lab();
        int edges;
        launch4(A_LAB, B_LAB, OP_LAB, 1'b0, edges);
        checks++; if (edges !== 3) begin errors++; $display("FAIL lab_latency: got %0d edges want 3", edges); end
        checks++; if (if4.out_num !== {5'd20, 5'd9}) begin errors++; $display("FAIL lab_out_num: got %h want %h", if4.out_num, {5'd20, 5'd9}); end
        checks++; if (dbg4 !== 2'd2) begin errors++; $display("FAIL lab_state: got %0d want 2", dbg4); end
        @(posedge clk); #1;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL lab_handoff_valid: got %b want 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL lab_handoff_ready: got %b want 1", if4.in_ready); end
    endtask

    task automatic test_sorted8();
        int edges;
        launch8(A_SEQ, 32'd0, 16'h5555, 1'b0, edges);
        checks++; if (edges !== 5) begin errors++; $display("FAIL seq_asc_latency: got %0d edges want 5", edges); end
        checks++; if (if8.out_num !== {5'd15, 5'd11, 5'd7, 5'd3}) begin errors++; $display("FAIL seq_asc_out_num: got %h want %h", if8.out_num, {5'd15, 5'd11, 5'd7, 5'd3}); end
        @(posedge clk); #1;
        launch8(A_SEQ, 32'd0, 16'h5555, 1'b1, edges);
        checks++; if (edges !== 5) begin errors++; $display("FAIL seq_desc_latency: got %0d edges want 5", edges); end
        checks++; if (if8.out_num !== {5'd3, 5'd7, 5'd11, 5'd15}) begin errors++; $display("FAIL seq_desc_out_num: got %h want %h", if8.out_num, {5'd3, 5'd7, 5'd11, 5'd15}); end
        @(posedge clk); #1;
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL seq_handoff_ready: got %b want 1", if8.in_ready); end
    endtask

    task automatic test_ties();
        int edges;
        launch4(16'hFFFF, 16'hFFFF, 8'hFF, 1'b0, edges);
        checks++; if (edges !== 3) begin errors++; $display("FAIL ties_latency: got %0d edges want 3", edges); end
        checks++; if (if4.out_num !== {5'b11110, 5'b11110}) begin errors++; $display("FAIL ties_out_num: got %b want 1111011110", if4.out_num); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int edges;
        if4.out_ready = 1'b0;
        launch4(A_LAB, B_LAB, OP_LAB, 1'b1, edges);
        checks++; if (edges !== 3) begin errors++; $display("FAIL bp_latency: got %0d edges want 3", edges); end
        for (int c = 0; c < 10; c++) begin
            if4.in_valid = (c % 2 == 0);
            if4.in_a = 16'hABCD; if4.in_b = 16'h1234; if4.in_op = 8'h5A; if4.in_desc = 1'b0;
            @(posedge clk); #1;
            checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 1", c, if4.out_valid); end
            checks++; if (if4.out_num !== {5'd9, 5'd20}) begin errors++; $display("FAIL bp_out_num_c%0d: got %h want %h", c, if4.out_num, {5'd9, 5'd20}); end
            checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, if4.in_ready); end
        end
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", if4.in_ready); end
    endtask

    task automatic test_reset_mid_sort();
        int edges;
        if8.in_a = A_UNS; if8.in_b = 32'd0; if8.in_op = 16'h5555; if8.in_desc = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (dbg8 !== 2'd1) begin errors++; $display("FAIL rst_pre_state: got %0d want 1", dbg8); end
        rst_n = 1'b0;
        #1;
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", if8.out_valid); end
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", if8.in_ready); end
        checks++; if (if8.out_num !== 20'd0) begin errors++; $display("FAIL rst_mid_out_num: got %h want 0", if8.out_num); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch8(A_UNS, 32'd0, 16'h5555, 1'b0, edges);
        checks++; if (edges !== 5) begin errors++; $display("FAIL rst_asc_latency: got %0d edges want 5", edges); end
        checks++; if (if8.out_num !== {5'd15, 5'd11, 5'd7, 5'd3}) begin errors++; $display("FAIL rst_asc_out_num: got %h want %h", if8.out_num, {5'd15, 5'd11, 5'd7, 5'd3}); end
        @(posedge clk); #1;
        launch8(A_UNS, 32'd0, 16'h5555, 1'b1, edges);
        checks++; if (edges !== 5) begin errors++; $display("FAIL uns_desc_latency: got %0d edges want 5", edges); end
        checks++; if (if8.out_num !== {5'd3, 5'd7, 5'd11, 5'd15}) begin errors++; $display("FAIL uns_desc_out_num: got %h want %h", if8.out_num, {5'd3, 5'd7, 5'd11, 5'd15}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int edges;
        if4.out_ready = 1'b1;
        if4.in_a = A_LAB; if4.in_b = B_LAB; if4.in_op = OP_LAB; if4.in_desc = 1'b0; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept1: in_ready got %b want 0", if4.in_ready); end
        if4.in_a = A_P2; if4.in_b = B_P2; if4.in_op = 8'h00; if4.in_desc = 1'b1;
        while (if4.out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++; if (edges !== 3) begin errors++; $display("FAIL b2b_latency1: got %0d edges want 3", edges); end
        checks++; if (if4.out_num !== {5'd20, 5'd9}) begin errors++; $display("FAIL b2b_out_num1: got %h want %h", if4.out_num, {5'd20, 5'd9}); end
        checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready: got %b want 0", if4.in_ready); end
        @(posedge clk); #1;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_handoff_valid: got %b want 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b want 1", if4.in_ready); end
        @(posedge clk); #1;
        edges = 1;
        if4.in_valid = 1'b0;
        checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2: in_ready got %b want 0", if4.in_ready); end
        while (if4.out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++; if (edges !== 3) begin errors++; $display("FAIL b2b_latency2: got %0d edges want 3", edges); end
        checks++; if (if4.out_num !== {5'd8, 5'd15}) begin errors++; $display("FAIL b2b_out_num2: got %h want %h", if4.out_num, {5'd8, 5'd15}); end
        @(posedge clk); #1;
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_final_ready: got %b want 1", if4.in_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.in_op = '0; if4.in_desc = 1'b0; if4.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_op = '0; if8.in_desc = 1'b0; if8.out_ready = 1'b1;
        test_reset();
        test_lab();
        test_sorted8();
        test_ties();
        test_backpressure();
        test_reset_mid_sort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
